// File: rtl/zxw_pmm_arbiter.sv
// zxw_pmm_arbiter: round-robin burst arbiter sharing the program ROM
// between the I-cache refill port and a secondary reader.
module zxw_pmm_arbiter #(
    parameter int AW     = 14,
    parameter int DW     = 14,
    parameter int RD_LAT = 1
) (
    input  logic          Clock,
    input  logic          Resetn,
    input  logic          r0_req,
    input  logic [AW-1:0] r0_addr,
    input  logic [3:0]    r0_len,
    output logic          r0_gnt,
    output logic          r0_valid,
    output logic          r0_last,
    input  logic          r1_req,
    input  logic [AW-1:0] r1_addr,
    input  logic [3:0]    r1_len,
    output logic          r1_gnt,
    output logic          r1_valid,
    output logic          r1_last,
    output logic [DW-1:0] rd_data,
    output logic [AW-1:0] mem_addr,
    output logic          mem_rd,
    input  logic [DW-1:0] mem_data,
    output logic          busy
);
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_e;

    state_e            state_q;
    logic              owner_q;
    logic              last_owner_q;
    logic [3:0]        len_q;
    logic [3:0]        iss_cnt_q;
    logic [3:0]        ret_cnt_q;
    logic [AW-1:0]     addr_q;
    logic              mem_rd_q;
    logic [RD_LAT-1:0] pipe_q;
    logic [DW-1:0]     data_q;
    logic              gnt0_q, gnt1_q;
    logic              v0_q, l0_q, v1_q, l1_q;

    logic              pick1;
    logic [RD_LAT:0]   pipe_ext;
    logic              emerge;
    logic              is_last;

    // on a tie the requester that did not own the previous burst wins
    assign pick1    = r1_req & (~r0_req | ~last_owner_q);
    assign pipe_ext = {pipe_q, mem_rd_q};
    assign emerge   = pipe_ext[RD_LAT];
    assign is_last  = (ret_cnt_q == len_q);

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b1;
            len_q        <= '0;
            iss_cnt_q    <= '0;
            ret_cnt_q    <= '0;
            addr_q       <= '0;
            mem_rd_q     <= 1'b0;
            pipe_q       <= '0;
            data_q       <= '0;
            gnt0_q       <= 1'b0;
            gnt1_q       <= 1'b0;
            v0_q         <= 1'b0;
            l0_q         <= 1'b0;
            v1_q         <= 1'b0;
            l1_q         <= 1'b0;
        end else begin
            pipe_q <= pipe_ext[RD_LAT-1:0];
            v0_q   <= 1'b0;
            l0_q   <= 1'b0;
            v1_q   <= 1'b0;
            l1_q   <= 1'b0;
            if (emerge) begin
                data_q    <= mem_data;
                ret_cnt_q <= ret_cnt_q + 4'd1;
                v0_q      <= ~owner_q;
                v1_q      <= owner_q;
                l0_q      <= ~owner_q & is_last;
                l1_q      <= owner_q & is_last;
            end
            unique case (state_q)
                IDLE: begin
                    if (r0_req | r1_req) begin
                        state_q      <= ISSUE;
                        owner_q      <= pick1;
                        last_owner_q <= pick1;
                        addr_q       <= pick1 ? r1_addr : r0_addr;
                        len_q        <= pick1 ? r1_len : r0_len;
                        iss_cnt_q    <= pick1 ? r1_len : r0_len;
                        ret_cnt_q    <= '0;
                        mem_rd_q     <= 1'b1;
                        gnt0_q       <= ~pick1;
                        gnt1_q       <= pick1;
                    end
                end
                ISSUE: begin
                    if (iss_cnt_q == 4'd0) begin
                        mem_rd_q <= 1'b0;
                        state_q  <= DRAIN;
                    end else begin
                        addr_q    <= addr_q + AW'(1);
                        iss_cnt_q <= iss_cnt_q - 4'd1;
                    end
                end
                DRAIN: begin
                    // the last strobe is on the outputs this cycle
                    if (l0_q | l1_q) begin
                        state_q <= IDLE;
                        gnt0_q  <= 1'b0;
                        gnt1_q  <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign r0_gnt   = gnt0_q;
    assign r1_gnt   = gnt1_q;
    assign r0_valid = v0_q;
    assign r0_last  = l0_q;
    assign r1_valid = v1_q;
    assign r1_last  = l1_q;
    assign rd_data  = data_q;
    assign mem_addr = addr_q;
    assign mem_rd   = mem_rd_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_zxw_pmm_arbiter.sv
// tb_zxw_pmm_arbiter: directed and random checks of the ROM burst
// arbiter against a burst-window model, at read latencies 1 and 3.
module tb_zxw_pmm_arbiter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tot = 0;
    int n_bad = 0;

    function automatic logic [13:0] rom(input logic [13:0] a);
        return (a * 14'd37) ^ {a[6:0], a[13:7]} ^ 14'h1A5C;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, got, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : lane
        localparam int LAT = (g == 0) ? 1 : 3;

        logic        rst_n;
        logic [1:0]  req;
        logic [13:0] addr [2];
        logic [3:0]  len [2];
        logic        gnt0, v0, l0, gnt1, v1, l1;
        logic [13:0] rd_data, mem_addr, mem_data;
        logic        mem_rd, busy;
        logic [13:0] apipe [LAT];
        bit          fin = 1'b0;
        int          cyc = 0;

        // model: one burst window [m_s, m_e] per grant
        bit          w_v;
        int          m_s, m_e, m_len, m_own, m_lastown;
        logic [13:0] m_base;
        bit [1:0]    rearm;
        bit          rnd;
        int          done_cnt;

        zxw_pmm_arbiter #(.AW(14), .DW(14), .RD_LAT(LAT)) dut (
            .Clock(clk), .Resetn(rst_n),
            .r0_req(req[0]), .r0_addr(addr[0]), .r0_len(len[0]),
            .r0_gnt(gnt0), .r0_valid(v0), .r0_last(l0),
            .r1_req(req[1]), .r1_addr(addr[1]), .r1_len(len[1]),
            .r1_gnt(gnt1), .r1_valid(v1), .r1_last(l1),
            .rd_data(rd_data), .mem_addr(mem_addr), .mem_rd(mem_rd),
            .mem_data(mem_data), .busy(busy)
        );

        always @(posedge clk) begin
            apipe[0] <= mem_addr;
            for (int k = 1; k < LAT; k++) apipe[k] <= apipe[k-1];
        end
        assign mem_data = rom(apipe[LAT-1]);

        task automatic chk_cycle();
            bit          win, rd, vld, lst;
            logic [7:0]  exp_v, got_v;
            logic [13:0] ea;
            win = w_v && cyc >= m_s && cyc <= m_e;
            rd  = w_v && cyc >= m_s && cyc <= m_s + m_len;
            vld = win && cyc >= m_s + LAT + 1;
            lst = w_v && cyc == m_e;
            exp_v = {win, (win && m_own == 0), (win && m_own == 1), rd,
                     (vld && m_own == 0), (lst && m_own == 0),
                     (vld && m_own == 1), (lst && m_own == 1)};
            got_v = {busy, gnt0, gnt1, mem_rd, v0, l0, v1, l1};
            check_eq($sformatf("L%0d ctl c%0d", LAT, cyc),
                     32'(got_v), 32'(exp_v));
            if (rd) begin
                ea = m_base + 14'(cyc - m_s);
                check_eq($sformatf("L%0d addr c%0d", LAT, cyc),
                         32'(mem_addr), 32'(ea));
            end
            if (vld) begin
                ea = m_base + 14'(cyc - m_s - LAT - 1);
                check_eq($sformatf("L%0d data c%0d", LAT, cyc),
                         32'(rd_data), 32'(rom(ea)));
            end
        endtask

        task automatic arb();
            int pick;
            if (!rst_n || (w_v && cyc <= m_e) || req == 2'b00) return;
            if (req == 2'b11) pick = 1 - m_lastown;
            else pick = req[1] ? 1 : 0;
            m_own     = pick;
            m_lastown = pick;
            m_base    = addr[pick];
            m_len     = int'(len[pick]);
            m_s       = cyc + 1;
            m_e       = m_s + m_len + LAT + 1;
            w_v       = 1'b1;
        endtask

        task automatic drive();
            bit act;
            act = w_v && cyc <= m_e;
            if (act && cyc == m_e) begin
                done_cnt++;
                if (rnd) rearm[m_own] = 1'($urandom_range(0, 1));
                if (rearm[m_own]) begin
                    req[m_own] = 1'b1;
                    if (rnd) begin
                        addr[m_own] = 14'($urandom);
                        len[m_own]  = 4'($urandom);
                    end
                end else begin
                    req[m_own] = 1'b0;
                end
            end
            if (!rnd) return;
            for (int i = 0; i < 2; i++) begin
                if (act && i == m_own) begin
                    if (cyc < m_e && $urandom_range(0, 7) == 0) req[i] = 1'b0;
                    if (cyc < m_e && $urandom_range(0, 3) == 0) begin
                        addr[i] = 14'($urandom);
                        len[i]  = 4'($urandom);
                    end
                end else if (!req[i] && $urandom_range(0, 3) == 0) begin
                    req[i]  = 1'b1;
                    addr[i] = 14'($urandom);
                    len[i]  = 4'($urandom);
                end
            end
        endtask

        task automatic step();
            @(posedge clk);
            #1;
            cyc++;
            chk_cycle();
            drive();
            arb();
        endtask

        task automatic idle(input int n);
            repeat (n) step();
        endtask

        task automatic run_bursts(input int n);
            int tgt = done_cnt + n;
            int b = 0;
            while (done_cnt < tgt && b < 400) begin
                step();
                b++;
            end
            check_eq($sformatf("L%0d bursts", LAT), 32'(done_cnt >= tgt), 32'd1);
        endtask

        task automatic wait_word(input int w);
            int b = 0;
            while (!(w_v && cyc == m_s + LAT + w) && b < 100) begin
                step();
                b++;
            end
            check_eq($sformatf("L%0d word%0d", LAT, w),
                     32'(cyc == m_s + LAT + w), 32'd1);
        endtask

        task automatic go(input int i, input logic [13:0] a, input logic [3:0] l);
            req[i]  = 1'b1;
            addr[i] = a;
            len[i]  = l;
        endtask

        task automatic chk_zero(input string tag);
            check_eq($sformatf("L%0d %s ctl", LAT, tag),
                     32'({busy, gnt0, gnt1, mem_rd, v0, l0, v1, l1}), 32'd0);
            check_eq($sformatf("L%0d %s bus", LAT, tag),
                     32'({rd_data, mem_addr}), 32'd0);
        endtask

        task automatic do_reset();
            #3 rst_n = 1'b0;
            #1;
            chk_zero("rst");
            w_v       = 1'b0;
            m_lastown = 1;
            req       = 2'b00;
            rearm     = 2'b00;
            @(posedge clk);
            #1;
            cyc++;
            chk_zero("rsthold");
            rst_n = 1'b1;
        endtask

        initial begin
            int b;
            rst_n = 1'b1;
            req = 2'b00;
            addr[0] = '0; addr[1] = '0;
            len[0] = '0; len[1] = '0;
            w_v = 1'b0; m_lastown = 1; m_s = 0; m_e = 0;
            rearm = 2'b00; rnd = 1'b0; done_cnt = 0;
            do_reset();
            go(0, 14'h0200, 4'd3);
            go(1, 14'h0300, 4'd3);
            rearm = 2'b11;
            arb();
            run_bursts(4);
            req = 2'b00;
            rearm = 2'b00;
            idle(3);
            go(0, 14'h0120, 4'd15); arb(); run_bursts(1); idle(2);
            go(1, 14'h3FFE, 4'd3);  arb(); run_bursts(1); idle(2);
            go(0, 14'h0777, 4'd0);  arb(); run_bursts(1); idle(2);
            // r1 arrives mid-burst while r0 lets go of its request
            go(0, 14'h1000, 4'd15); arb();
            wait_word(5);
            req[0] = 1'b0;
            go(1, 14'h2000, 4'd2);
            run_bursts(2);
            idle(2);
            go(0, 14'h0A00, 4'd15); arb();
            wait_word(8);
            do_reset();
            go(0, 14'h0040, 4'd1);
            go(1, 14'h0050, 4'd1);
            arb();
            run_bursts(2);
            req = 2'b00;
            idle(3);
            rnd = 1'b1;
            idle(1500);
            rnd = 1'b0;
            rearm = 2'b00;
            req = 2'b00;
            b = 0;
            while (w_v && cyc <= m_e && b < 100) begin
                step();
                b++;
            end
            idle(2);
            fin = 1'b1;
        end
    end

    initial begin
        int b = 0;
        while (!(lane[0].fin && lane[1].fin) && b < 50000) begin
            @(posedge clk);
            b++;
        end
        check_eq("finish", 32'(lane[0].fin && lane[1].fin), 32'd1);
        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end
endmodule

// File: doc/zxw_pmm_arbiter.md
Name: zxw_pmm_arbiter

Overview:
- Shares the single synchronous program-memory ROM (14-bit address, 14-bit data) between two burst read requesters.
  - Requester 0: I-cache line refill.
  - Requester 1: secondary reader (debug/data table port).
- Grants whole bursts with round-robin fairness, issues sequential ROM addresses, and returns data with per-requester valid/last strobes.
- Sits between the cache controllers and the ROM; it is the only block driving the ROM address.

Parameters:
- AW, 14, memory address width.
- DW, 14, memory data width.
- RD_LAT, 1, ROM read latency in Clock cycles from address to data (legal 1..4).

Ports:
- Clock  in  1  single system clock; all state updates on posedge.
- Resetn  in  1  asynchronous, active-low reset.
- r0_req  in  1  requester 0 burst request; level, held until r0_last.
- r0_addr  in  AW  requester 0 burst base address.
- r0_len  in  4  requester 0 burst length minus one (0 = 1 word, 15 = 16 words).
- r0_gnt  out  1  requester 0 owns the memory.
- r0_valid  out  1  rd_data holds a requester 0 word this cycle.
- r0_last  out  1  final word of the requester 0 burst (coincides with r0_valid).
- r1_req, r1_addr, r1_len, r1_gnt, r1_valid, r1_last: same as requester 0, for requester 1.
- rd_data  out  DW  registered return data, shared by both requesters.
- mem_addr  out  AW  ROM address.
- mem_rd  out  1  ROM read enable.
- mem_data  in  DW  ROM output; valid RD_LAT cycles after the address.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (Resetn low, asynchronous): all outputs 0, FSM to IDLE, last_owner = 1 (r0 wins the first tie), all counters and the valid pipeline cleared.
  - Reset mid-burst aborts the burst. In-flight data is discarded, with no valid/last strobes.
- FSM states: IDLE, ISSUE, DRAIN.
- IDLE:
  - Only one req high: grant it.
  - Both high: grant the requester that is not last_owner.
  - Neither high: stay in IDLE.
  - On a grant: latch base address and len into internal registers; set rX_gnt; update last_owner; go to ISSUE.
  - Changes to rX_addr or rX_len after the grant cycle are ignored.
- ISSUE:
  - mem_rd = 1 for exactly len+1 consecutive cycles.
  - mem_addr = base + k for k = 0..len, wrapping modulo 2^AW (0x3FFF + 1 = 0x0000).
  - After the last issue, go to DRAIN.
- DRAIN: mem_rd = 0; wait until all issued words have returned, then go to IDLE.
- Data return:
  - A shift pipeline of depth RD_LAT tracks issued reads.
  - When a word emerges: rd_data <= mem_data, and the owner's rX_valid pulses for one cycle, so rd_data/rX_valid appear RD_LAT+1 cycles after the address.
  - rX_last is asserted with the (len+1)-th valid.
  - rd_data holds its value when no word returns.
  - Only the owner's valid/last ever assert.
- Grant timing: rX_gnt goes high in the cycle the first address is driven and stays high through the cycle of rX_last, then drops.
- Latency and throughput:
  - req high in IDLE → first mem_rd on the next edge.
  - One IDLE cycle always separates consecutive bursts.
  - Peak rate is one word per cycle.
- Requester protocol:
  - req deasserted mid-burst: ignored; the burst completes.
  - req still high after last: treated as a new request, subject to round-robin.
- Simultaneous events: a new req during a burst waits. At the next IDLE, round-robin order guarantees the waiting requester is served before the previous owner repeats.
- busy = (state != IDLE).

Test Plan:
- Single burst: r0_req, r0_addr = 0x0120, r0_len = 15, RD_LAT = 1.
  - Expect mem_addr 0x0120..0x012F on 16 consecutive cycles.
  - Expect 16 r0_valid pulses, the first 2 cycles after the first address, with r0_last on the 16th.
  - Expect r1 strobes to stay 0.
- Tie arbitration: r0 and r1 both request from reset, len = 3 each.
  - Expect r0 burst first, one IDLE gap, then r1 burst.
  - Then with both held high: r0 again, then r1 (alternation).
- Wrap-around: r1_addr = 0x3FFE, r1_len = 3.
  - Expect mem_addr sequence 0x3FFE, 0x3FFF, 0x0000, 0x0001.
  - Expect 4 valid strobes with correct ROM data.
- Latency sweep: RD_LAT = 3, len = 0.
  - Expect a single mem_rd cycle, DRAIN until data returns, r0_valid and r0_last together 4 cycles after the address.
  - Expect busy low on the following cycle.
- Mid-burst changes: r1 requests during an r0 len = 15 burst, and r0_req drops at word 5.
  - Expect the r0 burst to complete all 16 words, then r1 granted after one IDLE cycle.
- Reset mid-burst: pull Resetn low at word 8 of a 16-word burst.
  - Expect all outputs 0 immediately.
  - After release: no stray valid strobes, and a tie grants r0 first.
